// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin write controller sharing one `register`
// instance between NB_REQ requesters. The winner's word is latched and driven
// on reg_data_o with reg_enable_o high for HOLD_CYCLES cycles, then ack_o pulses.
// Latency: req_i seen at edge t -> GRANT t+1..t+HOLD_CYCLES -> ACK t+HOLD_CYCLES+1.
// Backpressure: requests arriving outside IDLE are not sampled; they wait for IDLE.
//
// Ports:
//   clock_i, resetb_i          clock (rising edge), async active-low reset
//   req_i[NB_REQ]              per-requester request, held until its ack_o bit
//   data_req_i[NB_REQ*nb_bits] flattened words, requester k at [k*nb_bits +: nb_bits]
//   ack_o[NB_REQ]              one-hot, one-cycle completion pulse
//   reg_data_o, reg_enable_o   to the register's data_i / enable_i
//   grant_id_o                 current winner index (0 in IDLE)
//   busy_o                     high whenever the FSM is not IDLE
//
// Build option: define REG_ARB_FIXED_PRIO_EN for fixed priority (lowest set
// req_i index wins, pointer held at 0). Default build is round-robin.

module reg_write_arbiter #(
  parameter int NB_REQ      = 4,
  parameter int nb_bits     = 32,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                        clock_i,
  input  logic                        resetb_i,
  input  logic [NB_REQ-1:0]           req_i,
  input  logic [NB_REQ*nb_bits-1:0]   data_req_i,
  output logic [NB_REQ-1:0]           ack_o,
  output logic [nb_bits-1:0]          reg_data_o,
  output logic                        reg_enable_o,
  output logic [$clog2(NB_REQ)-1:0]   grant_id_o,
  output logic                        busy_o
);

  localparam int IDW = $clog2(NB_REQ);
  localparam int HCW = $clog2(HOLD_CYCLES + 1);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NB_REQ - 1);
  localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  state_t              r_state;
  logic [HCW-1:0]      r_hold_cnt;
  logic [IDW-1:0]      r_win;
  logic [IDW-1:0]      r_ptr;
  logic [nb_bits-1:0]  r_data;

  state_t              w_state_nxt;
  logic [HCW-1:0]      w_hold_nxt;
  logic [IDW-1:0]      w_win_nxt;
  logic [IDW-1:0]      w_ptr_nxt;
  logic [nb_bits-1:0]  w_data_nxt;

  logic [IDW-1:0]      w_cand;
  logic [IDW-1:0]      w_sel;
  logic                w_found;
  logic [nb_bits-1:0]  w_word;

  // Scan upward from the pointer with wrap. In the fixed-priority build the
  // pointer never leaves 0, so the same scan yields the lowest set index.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = r_ptr;
    for (int i = 0; i < NB_REQ; i++) begin
      if (i != 0) begin
        if (w_cand == LAST_ID) w_cand = '0;
        else                   w_cand = w_cand + 1'b1;
      end
      if (!w_found && req_i[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  // Word of the selected requester
  always_comb begin
    w_word = '0;
    for (int k = 0; k < NB_REQ; k++) begin
      if (w_sel == IDW'(k)) w_word = data_req_i[k*nb_bits +: nb_bits];
    end
  end

  // State register
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_state    <= S_IDLE;
      r_hold_cnt <= '0;
      r_win      <= '0;
      r_ptr      <= '0;
      r_data     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_win      <= w_win_nxt;
      r_ptr      <= w_ptr_nxt;
      r_data     <= w_data_nxt;
    end
  end

  // Next-state and outputs; outputs depend only on registered state so there
  // is no input-to-output combinational path, and reset clears them at once.
  always_comb begin
    w_state_nxt  = r_state;
    w_hold_nxt   = r_hold_cnt;
    w_win_nxt    = r_win;
    w_ptr_nxt    = r_ptr;
    w_data_nxt   = r_data;
    ack_o        = '0;
    reg_data_o   = '0;
    reg_enable_o = 1'b0;
    grant_id_o   = '0;
    busy_o       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_GRANT;
          w_win_nxt   = w_sel;
          w_data_nxt  = w_word;
          w_hold_nxt  = HOLD_LOAD;
        end
      end

      S_GRANT: begin
        reg_enable_o = 1'b1;
        reg_data_o   = r_data;
        grant_id_o   = r_win;
        busy_o       = 1'b1;
        if (r_hold_cnt == '0) w_state_nxt = S_ACK;
        else                  w_hold_nxt  = r_hold_cnt - 1'b1;
      end

      S_ACK: begin
        ack_o[r_win] = 1'b1;
        grant_id_o   = r_win;
        busy_o       = 1'b1;
        w_state_nxt  = S_IDLE;
`ifdef REG_ARB_FIXED_PRIO_EN
        w_ptr_nxt    = '0;
`else
        if (r_win == LAST_ID) w_ptr_nxt = '0;
        else                  w_ptr_nxt = r_win + 1'b1;
`endif
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter (NB_REQ=4, nb_bits=32, HOLD_CYCLES=2).
// Expected grants are queued when requests are driven and checked on each ack.
// Inputs driven 1 time unit after the rising edge; the monitor samples on the falling edge.

module tb_reg_write_arbiter;

  localparam int NB   = 4;
  localparam int W    = 32;
  localparam int HOLD = 2;

  logic            clk = 1'b0;
  logic            rstn;
  logic [NB-1:0]   req;
  logic [NB*W-1:0] data;
  logic [NB-1:0]   ack_o;
  logic [W-1:0]    reg_data_o;
  logic            reg_enable_o;
  logic [1:0]      grant_id_o;
  logic            busy_o;

  reg_write_arbiter #(.NB_REQ(NB), .nb_bits(W), .HOLD_CYCLES(HOLD)) dut (
    .clock_i      (clk),
    .resetb_i     (rstn),
    .req_i        (req),
    .data_req_i   (data),
    .ack_o        (ack_o),
    .reg_data_o   (reg_data_o),
    .reg_enable_o (reg_enable_o),
    .grant_id_o   (grant_id_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] word;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          en_cnt = 0;
  logic [31:0] seen;
  logic [31:0] words [NB];
  exp_t        mon_e;
  logic [3:0]  mon_hot;

  // Scoreboard monitor: tracks the enable window and checks each ack
  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      en_cnt = 0;
    end else begin
      if (reg_enable_o) begin
        if (en_cnt > 0) begin
          checks++;
          if (reg_data_o !== seen) begin
            errors++;
            $display("FAIL data_stable: reg_data_o=%h was %h", reg_data_o, seen);
          end
        end
        seen = reg_data_o;
        en_cnt++;
      end
      if (ack_o !== 4'b0000) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: ack_o=%b with nothing pending", ack_o);
        end else begin
          mon_e   = exp_q.pop_front();
          mon_hot = 4'b0001 << mon_e.id;
          checks++;
          if (ack_o !== mon_hot) begin
            errors++;
            $display("FAIL ack_onehot: ack_o=%b expected %b", ack_o, mon_hot);
          end
          checks++;
          if (grant_id_o !== mon_e.id) begin
            errors++;
            $display("FAIL ack_grant_id: grant_id_o=%0d expected %0d", grant_id_o, mon_e.id);
          end
          checks++;
          if (seen !== mon_e.word) begin
            errors++;
            $display("FAIL written_word: got %h expected %h", seen, mon_e.word);
          end
          checks++;
          if (en_cnt != HOLD) begin
            errors++;
            $display("FAIL enable_len: %0d cycles expected %0d", en_cnt, HOLD);
          end
        end
        en_cnt = 0;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int id);
    exp_t e;
    e.id   = id[1:0];
    e.word = words[id];
    exp_q.push_back(e);
  endtask

  task automatic do_reset;
    rstn = 1'b0;
    req  = '0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (ack_o !== 4'b0)   begin errors++; $display("FAIL rst_ack: %b expected 0", ack_o); end
    checks++; if (reg_data_o !== 0) begin errors++; $display("FAIL rst_data: %h expected 0", reg_data_o); end
    checks++; if (reg_enable_o !== 1'b0) begin errors++; $display("FAIL rst_enable: %b expected 0", reg_enable_o); end
    checks++; if (grant_id_o !== 2'd0) begin errors++; $display("FAIL rst_grant_id: %0d expected 0", grant_id_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: %b expected 0", busy_o); end

    // Complete a grant to 1 so the pointer moves away from 0
    push_exp(1);
    req = 4'b0010;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
      step();
      req = req & ~ack_o;
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rst_prep_timeout: %0d grants pending expected 0", exp_q.size()); end

    // Start a grant to 2 and abort it in its second GRANT cycle
    req = 4'b0100;
    step();
    step();
    checks++;
    if (reg_enable_o !== 1'b1) begin errors++; $display("FAIL rst_mid_grant: enable=%b expected 1", reg_enable_o); end
    rstn = 1'b0;
    #1;
    checks++; if (reg_enable_o !== 1'b0) begin errors++; $display("FAIL abort_enable: %b expected 0", reg_enable_o); end
    checks++; if (reg_data_o !== 0) begin errors++; $display("FAIL abort_data: %h expected 0", reg_data_o); end
    checks++; if (ack_o !== 4'b0) begin errors++; $display("FAIL abort_ack: %b expected 0", ack_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy: %b expected 0", busy_o); end
    checks++; if (grant_id_o !== 2'd0) begin errors++; $display("FAIL abort_grant_id: %0d expected 0", grant_id_o); end
    repeat (2) @(posedge clk);
    #1;
    req  = 4'b0000;
    rstn = 1'b1;

    // Pointer must be back at 0: requester 0 wins over all others
    push_exp(0);
    req = 4'b1111;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
      step();
      if (ack_o !== 4'b0) req = 4'b0000;
    end
    repeat (4) step();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rst_ptr_timeout: %0d grants pending expected 0", exp_q.size()); end
  endtask

  task automatic test_single;
    do_reset();
    push_exp(1);
    req = 4'b0010;
    #1;
    checks++;
    if (reg_enable_o !== 1'b0) begin errors++; $display("FAIL single_no_comb: enable=%b expected 0", reg_enable_o); end
    for (int g = 0; g < HOLD; g++) begin
      step();
      checks++;
      if (reg_enable_o !== 1'b1) begin errors++; $display("FAIL single_enable%0d: %b expected 1", g, reg_enable_o); end
      checks++;
      if (reg_data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data%0d: %h expected deadbeef", g, reg_data_o); end
      checks++;
      if (grant_id_o !== 2'd1) begin errors++; $display("FAIL single_gid%0d: %0d expected 1", g, grant_id_o); end
    end
    step();
    checks++; if (ack_o !== 4'b0010) begin errors++; $display("FAIL single_ack: %b expected 0010", ack_o); end
    checks++; if (reg_enable_o !== 1'b0) begin errors++; $display("FAIL single_ack_enable: %b expected 0", reg_enable_o); end
    checks++; if (reg_data_o !== 0) begin errors++; $display("FAIL single_ack_data: %h expected 0", reg_data_o); end
    checks++; if (grant_id_o !== 2'd1) begin errors++; $display("FAIL single_ack_gid: %0d expected 1", grant_id_o); end
    req = 4'b0000;
    step();
    checks++; if (ack_o !== 4'b0) begin errors++; $display("FAIL single_ack_len: %b expected 0", ack_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single_idle_busy: %b expected 0", busy_o); end
    checks++; if (grant_id_o !== 2'd0) begin errors++; $display("FAIL single_idle_gid: %0d expected 0", grant_id_o); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL single_pending: %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_round_robin;
    int nack;
    int last;
    logic [3:0] rearm;
    do_reset();
    push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
    nack  = 0;
    last  = 0;
    rearm = '0;
    req   = 4'b1111;
    for (int c = 0; c < 60 && nack < 5; c++) begin
      step();
      req   = req | rearm;
      rearm = '0;
      if (ack_o !== 4'b0) begin
        nack++;
        if (nack > 1) begin
          checks++;
          if (cyc - last != HOLD + 2) begin
            errors++;
            $display("FAIL rr_ack_spacing: %0d cycles expected %0d", cyc - last, HOLD + 2);
          end
        end
        last = cyc;
        if (nack == 5) begin
          req = 4'b0000;
        end else begin
          rearm = ack_o;
          req   = req & ~ack_o;
        end
      end
    end
    repeat (3) step();
    checks++;
    if (nack != 5) begin errors++; $display("FAIL rr_ack_count: %0d expected 5", nack); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rr_pending: %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_wrap;
    do_reset();
    push_exp(2);
    req = 4'b0100;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
      step();
      req = req & ~ack_o;
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_prep: %0d pending expected 0", exp_q.size()); end
`ifdef REG_ARB_FIXED_PRIO_EN
    push_exp(0); push_exp(3);
`else
    push_exp(3); push_exp(0);
`endif
    req = 4'b1001;
    for (int c = 0; c < 30 && exp_q.size() != 0; c++) begin
      step();
      req = req & ~ack_o;
    end
    repeat (3) step();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_pending: %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_drop;
    do_reset();
    push_exp(2);
    req = 4'b0100;
    step();
    req = 4'b0000;
    step();
    checks++;
    if (reg_enable_o !== 1'b1) begin errors++; $display("FAIL drop_enable: %b expected 1", reg_enable_o); end
    checks++;
    if (reg_data_o !== words[2]) begin errors++; $display("FAIL drop_data: %h expected %h", reg_data_o, words[2]); end
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
    repeat (2) step();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL drop_pending: %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_fixed_prio;
    int nack;
    logic [3:0] rearm;
    do_reset();
    push_exp(1); push_exp(1); push_exp(1);
    nack  = 0;
    rearm = '0;
    req   = 4'b1010;
    for (int c = 0; c < 40 && nack < 3; c++) begin
      step();
      req   = req | rearm;
      rearm = '0;
      if (ack_o !== 4'b0) begin
        nack++;
        if (nack == 3) req = 4'b0000;
        else begin
          rearm = ack_o;
          req   = req & ~ack_o;
        end
      end
    end
    repeat (3) step();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL fixed_pending: %0d expected 0", exp_q.size()); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn     = 1'b0;
    req      = '0;
    words[0] = 32'hA5A5_0000;
    words[1] = 32'hDEADBEEF;
    words[2] = 32'h1234_5678;
    words[3] = 32'hCAFE_F00D;
    for (int k = 0; k < NB; k++) data[k*W +: W] = words[k];

    test_reset();
    test_single();
`ifdef REG_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_round_robin();
`endif
    test_wrap();
    test_drop();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
